// File: rtl/pc_unit_pkg.sv
// rtl/pc_unit_pkg.sv - shared cpu_defs package: next-PC source and branch-op encodings
package cpu_defs;

  typedef enum logic [2:0] {
    PC_SRC_ALU    = 3'd0,
    PC_SRC_ALUOUT = 3'd1,
    PC_SRC_JUMP   = 3'd2,
    PC_SRC_REGA   = 3'd3,
    PC_SRC_EPC    = 3'd4,
    PC_SRC_EXC    = 3'd5
  } pc_src_e;

  typedef enum logic [1:0] {
    BR_EQ = 2'd0,
    BR_NE = 2'd1,
    BR_LE = 2'd2,
    BR_GT = 2'd3
  } br_op_e;

endpackage

// File: rtl/pc_unit_next_mux.sv
// rtl/pc_unit_next_mux.sv - combinational next-PC selector and branch-condition decode
module pc_next_mux
  import cpu_defs::*;
(
  input  logic [2:0]  i_pc_source,
  input  logic [1:0]  i_branch_op,
  input  logic        i_zero,
  input  logic        i_lt,
  input  logic [31:0] i_alu_result,
  input  logic [31:0] i_alu_out,
  input  logic [31:0] i_jump_target,
  input  logic [31:0] i_reg_a,
  input  logic [31:0] i_epc,
  input  logic [31:0] i_exc_vector,
  output logic [31:0] o_next_pc,
  output logic        o_cond
);

  // Reserved selects 6 and 7 fall through to the ALU result.
  always_comb begin
    o_next_pc = i_alu_result;
    case (i_pc_source)
      PC_SRC_ALUOUT: o_next_pc = i_alu_out;
      PC_SRC_JUMP:   o_next_pc = i_jump_target;
      PC_SRC_REGA:   o_next_pc = i_reg_a;
      PC_SRC_EPC:    o_next_pc = i_epc;
      PC_SRC_EXC:    o_next_pc = i_exc_vector;
      default:       o_next_pc = i_alu_result;
    endcase
  end

  always_comb begin
    o_cond = 1'b0;
    case (i_branch_op)
      BR_EQ:   o_cond = i_zero;
      BR_NE:   o_cond = !i_zero;
      BR_LE:   o_cond = i_zero | i_lt;
      BR_GT:   o_cond = !i_zero & !i_lt;
      default: o_cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - PC and EPC registers with conditional write and misalignment flag
module pc_unit
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter bit          EXC_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  PCSource,
  input  logic        PCWrite,
  input  logic        PCWriteCond,
  input  logic [1:0]  BranchOp,
  input  logic        Zero,
  input  logic        LT,
  input  logic        EPCWrite,
  input  logic [31:0] alu_result,
  input  logic [31:0] alu_out,
  input  logic [31:0] jump_target,
  input  logic [31:0] reg_a,
  input  logic [31:0] exc_vector,
  input  logic [31:0] epc_in,
  input  logic        misalign_clr,
  output logic [31:0] PC_out,
  output logic [31:0] epc_out,
  output logic        pc_misaligned
);

  logic [31:0] r_pc;
  logic [31:0] r_epc;
  logic        r_misaligned;
  logic [31:0] w_next_pc;
  logic        w_cond;
  logic        w_take;
  logic        w_bad;

  pc_next_mux u_next_mux (
    .i_pc_source  (PCSource),
    .i_branch_op  (BranchOp),
    .i_zero       (Zero),
    .i_lt         (LT),
    .i_alu_result (alu_result),
    .i_alu_out    (alu_out),
    .i_jump_target(jump_target),
    .i_reg_a      (reg_a),
    .i_epc        (r_epc),
    .i_exc_vector (exc_vector),
    .o_next_pc    (w_next_pc),
    .o_cond       (w_cond)
  );

  assign w_take = PCWrite | (PCWriteCond & w_cond);
  assign w_bad  = EXC_CHECK && (w_next_pc[1:0] != 2'b00);

  // EPC load is independent of the PC write; a same-cycle set beats the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc         <= RESET_PC;
      r_epc        <= 32'h0000_0000;
      r_misaligned <= 1'b0;
    end else begin
      if (w_take && !w_bad) r_pc <= w_next_pc;
      if (EPCWrite) r_epc <= epc_in;
      if (w_take && w_bad) r_misaligned <= 1'b1;
      else if (misalign_clr) r_misaligned <= 1'b0;
    end
  end

  assign PC_out        = r_pc;
  assign epc_out       = r_epc;
  assign pc_misaligned = r_misaligned;

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed self-checking bench for pc_unit
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  PCSource;
  logic        PCWrite, PCWriteCond, Zero, LT, EPCWrite, misalign_clr;
  logic [1:0]  BranchOp;
  logic [31:0] alu_result, alu_out, jump_target, reg_a, exc_vector, epc_in;
  logic [31:0] PC_out, epc_out;
  logic        pc_misaligned;

  int checks = 0;
  int failures = 0;

  pc_unit dut (
    .clk          (clk),
    .reset        (reset),
    .PCSource     (PCSource),
    .PCWrite      (PCWrite),
    .PCWriteCond  (PCWriteCond),
    .BranchOp     (BranchOp),
    .Zero         (Zero),
    .LT           (LT),
    .EPCWrite     (EPCWrite),
    .alu_result   (alu_result),
    .alu_out      (alu_out),
    .jump_target  (jump_target),
    .reg_a        (reg_a),
    .exc_vector   (exc_vector),
    .epc_in       (epc_in),
    .misalign_clr (misalign_clr),
    .PC_out       (PC_out),
    .epc_out      (epc_out),
    .pc_misaligned(pc_misaligned)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    PCWrite = 0; PCWriteCond = 0; EPCWrite = 0; misalign_clr = 0;
  endtask

  task automatic load_pc(input logic [31:0] v);
    PCSource = 3'd0; alu_result = v; PCWrite = 1;
    step();
    idle();
  endtask

  initial begin
    logic [15:0] br_take;
    logic [31:0] exp_pc;
    br_take = 16'h1E3C;

    reset = 1; PCSource = 0; BranchOp = 0; Zero = 0; LT = 0;
    alu_result = 0; alu_out = 0; jump_target = 0; reg_a = 0; exc_vector = 0; epc_in = 0;
    idle();
    step(); step();
    check("reset_pc", PC_out, 32'h0);
    check("reset_epc", epc_out, 32'h0);
    check("reset_flag", {31'b0, pc_misaligned}, 32'h0);
    reset = 0;

    PCSource = 3'd0; alu_result = 32'h4; PCWrite = 1;
    step();
    check("fetch_write", PC_out, 32'h4);
    PCWrite = 0;
    step();
    check("fetch_hold", PC_out, 32'h4);

    PCSource = 3'd2; jump_target = 32'h0040_0100; PCWrite = 1;
    step();
    check("jump", PC_out, 32'h0040_0100);
    idle();

    PCSource = 3'd6; alu_result = 32'h0000_0200; PCWrite = 1;
    step();
    check("reserved_src6", PC_out, 32'h0000_0200);
    idle();

    alu_out = 32'h80;
    for (int i = 0; i < 16; i++) begin
      load_pc(32'h40);
      PCSource = 3'd1; BranchOp = i[3:2]; Zero = i[1]; LT = i[0]; PCWriteCond = 1;
      step();
      exp_pc = br_take[i] ? 32'h80 : 32'h40;
      check($sformatf("branch_op%0d_z%0d_lt%0d", i[3:2], i[1], i[0]), PC_out, exp_pc);
      idle();
    end

    load_pc(32'h40);
    PCSource = 3'd1; BranchOp = 2'd0; Zero = 0; LT = 0; PCWrite = 1; PCWriteCond = 1;
    step();
    check("uncond_overrides_cond", PC_out, 32'h80);
    idle();

    PCSource = 3'd3; reg_a = 32'h102; PCWrite = 1;
    step();
    check("misalign_pc_hold", PC_out, 32'h80);
    check("misalign_flag_set", {31'b0, pc_misaligned}, 32'h1);
    idle();
    load_pc(32'h100);
    check("good_write_after_bad", PC_out, 32'h100);
    check("flag_sticky", {31'b0, pc_misaligned}, 32'h1);
    misalign_clr = 1;
    step();
    check("flag_cleared", {31'b0, pc_misaligned}, 32'h0);
    idle();
    PCSource = 3'd3; reg_a = 32'h102; PCWrite = 1;
    step();
    idle();
    PCSource = 3'd3; reg_a = 32'h103; PCWrite = 1; misalign_clr = 1;
    step();
    check("set_beats_clr", {31'b0, pc_misaligned}, 32'h1);
    check("set_beats_clr_pc", PC_out, 32'h100);
    idle();
    misalign_clr = 1;
    step();
    idle();

    EPCWrite = 1; epc_in = 32'h1C; PCSource = 3'd5; exc_vector = 32'hFC; PCWrite = 1;
    step();
    check("exc_epc", epc_out, 32'h1C);
    check("exc_pc", PC_out, 32'hFC);
    idle();
    PCSource = 3'd4; PCWrite = 1;
    step();
    check("eret_pc", PC_out, 32'h1C);
    idle();

    EPCWrite = 1; epc_in = 32'h300; PCSource = 3'd4; PCWrite = 1;
    step();
    check("epc_same_cycle_old", PC_out, 32'h1C);
    check("epc_same_cycle_new", epc_out, 32'h300);
    idle();

    load_pc(32'h40);
    check("pre_reset_pc", PC_out, 32'h40);
    #2 reset = 1;
    #1;
    check("async_reset_pc", PC_out, 32'h0);
    check("async_reset_epc", epc_out, 32'h0);
    PCSource = 3'd0; alu_result = 32'h44; PCWrite = 1;
    step();
    check("write_during_reset", PC_out, 32'h0);
    idle();
    reset = 0;
    step();
    check("post_reset_hold", PC_out, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
